// File: rtl/l15_arbiter_if.sv
// l15_arbiter_if: IF/DM request, response and L1.5 transducer signals; slave = arbiter side, master = requesters plus L1.5 side
interface l15_arbiter_if;
  logic        if_req_val, dm_req_val;
  logic [4:0]  if_req_rqtype, dm_req_rqtype;
  logic [2:0]  if_req_size, dm_req_size;
  logic [31:0] if_req_addr, dm_req_addr;
  logic [63:0] if_req_data, dm_req_data;
  logic        if_req_ack, dm_req_ack;
  logic        if_resp_val, dm_resp_val;
  logic [63:0] resp_data_0, resp_data_1;
  logic [31:0] resp_returntype;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [31:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_val;
  logic        l15_transducer_ack, l15_transducer_val;
  logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
  logic [31:0] l15_transducer_returntype;
  logic        transducer_l15_req_ack;
  logic        busy;
  modport slave (
    input  if_req_val, dm_req_val, if_req_rqtype, dm_req_rqtype, if_req_size, dm_req_size,
           if_req_addr, dm_req_addr, if_req_data, dm_req_data,
           l15_transducer_ack, l15_transducer_val, l15_transducer_data_0, l15_transducer_data_1,
           l15_transducer_returntype,
    output if_req_ack, dm_req_ack, if_resp_val, dm_resp_val, resp_data_0, resp_data_1, resp_returntype,
           transducer_l15_rqtype, transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_val, transducer_l15_req_ack, busy
  );
  modport master (
    output if_req_val, dm_req_val, if_req_rqtype, dm_req_rqtype, if_req_size, dm_req_size,
           if_req_addr, dm_req_addr, if_req_data, dm_req_data,
           l15_transducer_ack, l15_transducer_val, l15_transducer_data_0, l15_transducer_data_1,
           l15_transducer_returntype,
    input  if_req_ack, dm_req_ack, if_resp_val, dm_resp_val, resp_data_0, resp_data_1, resp_returntype,
           transducer_l15_rqtype, transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_val, transducer_l15_req_ack, busy
  );
endinterface

// File: rtl/l15_arbiter.sv
// l15_arbiter: arbitrates IF/DM requests onto one L1.5 transaction at a time (ports clk, rst, bus: l15_arbiter_if.slave); define L15_ARB_ROUND_ROBIN_EN for round-robin ties, else DM has fixed priority
module l15_arbiter (
  input logic clk,
  input logic rst,
  l15_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;
  state_t state;
  logic owner_dm;
  logic grant_dm;
`ifdef L15_ARB_ROUND_ROBIN_EN
  logic last_dm;
  assign grant_dm = bus.dm_req_val & (~bus.if_req_val | ~last_dm);
`else
  assign grant_dm = bus.dm_req_val;
`endif
  assign bus.transducer_l15_val = state == SEND;
  assign bus.busy = state != IDLE;
  assign bus.transducer_l15_req_ack = bus.l15_transducer_val & ~rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner_dm <= 1'b0;
`ifdef L15_ARB_ROUND_ROBIN_EN
      last_dm <= 1'b0;
`endif
      bus.transducer_l15_rqtype <= '0;
      bus.transducer_l15_size <= '0;
      bus.transducer_l15_address <= '0;
      bus.transducer_l15_data <= '0;
      bus.if_req_ack <= 1'b0;
      bus.dm_req_ack <= 1'b0;
      bus.if_resp_val <= 1'b0;
      bus.dm_resp_val <= 1'b0;
      bus.resp_data_0 <= '0;
      bus.resp_data_1 <= '0;
      bus.resp_returntype <= '0;
    end else begin
      bus.if_req_ack <= 1'b0;
      bus.dm_req_ack <= 1'b0;
      bus.if_resp_val <= 1'b0;
      bus.dm_resp_val <= 1'b0;
      case (state)
        IDLE: if (bus.if_req_val | bus.dm_req_val) begin
          state <= SEND;
          owner_dm <= grant_dm;
`ifdef L15_ARB_ROUND_ROBIN_EN
          last_dm <= grant_dm;
`endif
          bus.transducer_l15_rqtype <= grant_dm ? bus.dm_req_rqtype : bus.if_req_rqtype;
          bus.transducer_l15_size <= grant_dm ? bus.dm_req_size : bus.if_req_size;
          bus.transducer_l15_address <= grant_dm ? bus.dm_req_addr : bus.if_req_addr;
          bus.transducer_l15_data <= grant_dm ? bus.dm_req_data : bus.if_req_data;
        end
        SEND: if (bus.l15_transducer_ack) begin
          state <= WAIT_RESP;
          bus.if_req_ack <= ~owner_dm;
          bus.dm_req_ack <= owner_dm;
        end
        WAIT_RESP: if (bus.l15_transducer_val) begin
          state <= IDLE;
          bus.resp_data_0 <= bus.l15_transducer_data_0;
          bus.resp_data_1 <= bus.l15_transducer_data_1;
          bus.resp_returntype <= bus.l15_transducer_returntype;
          bus.if_resp_val <= ~owner_dm;
          bus.dm_resp_val <= owner_dm;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l15_arbiter.sv
// tb_l15_arbiter: randomized self-checking bench for l15_arbiter against a queue-based arbitration model
module tb_l15_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  l15_arbiter_if bus();
  l15_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef L15_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic        dm;
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] data;
  } req_t;
  req_t if_q[$], dm_q[$], seen_q[$];
  logic ack_q[$], rown_q[$], exp_own[$];
  logic [63:0] rd0_q[$];
  logic [31:0] rrt_q[$];
  int errors = 0, checks = 0;
  int if_acks = 0, dm_acks = 0, if_resps = 0, dm_resps = 0, both = 0;
  bit auto_l15 = 1'b0, rand_lat = 1'b0, timed_out;
  int ack_lat = 0, resp_lat = 0, r_phase = 0, r_cnt = 0;
  logic [63:0] salt = '0;
  req_t lr, dr;
  always @(negedge clk) begin
    if (bus.if_req_ack) begin if_acks++; ack_q.push_back(1'b0); end
    if (bus.dm_req_ack) begin dm_acks++; ack_q.push_back(1'b1); end
    if (bus.if_resp_val) begin if_resps++; rown_q.push_back(1'b0); rd0_q.push_back(bus.resp_data_0); rrt_q.push_back(bus.resp_returntype); end
    if (bus.dm_resp_val) begin dm_resps++; rown_q.push_back(1'b1); rd0_q.push_back(bus.resp_data_0); rrt_q.push_back(bus.resp_returntype); end
    if ((bus.if_req_ack && bus.dm_req_ack) || (bus.if_resp_val && bus.dm_resp_val)) both++;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.if_req_ack) bus.if_req_val = 1'b0;
    if (bus.dm_req_ack) bus.dm_req_val = 1'b0;
    if (!bus.if_req_val && if_q.size() > 0) begin
      dr = if_q.pop_front();
      bus.if_req_val = 1'b1; bus.if_req_rqtype = dr.rqtype; bus.if_req_size = dr.size;
      bus.if_req_addr = dr.addr; bus.if_req_data = dr.data;
    end
    if (!bus.dm_req_val && dm_q.size() > 0) begin
      dr = dm_q.pop_front();
      bus.dm_req_val = 1'b1; bus.dm_req_rqtype = dr.rqtype; bus.dm_req_size = dr.size;
      bus.dm_req_addr = dr.addr; bus.dm_req_data = dr.data;
    end
    if (auto_l15) begin
      bus.l15_transducer_ack = 1'b0;
      bus.l15_transducer_val = 1'b0;
      if (r_phase == 0 && bus.transducer_l15_val) begin
        r_phase = 1;
        r_cnt = rand_lat ? int'($urandom_range(0, 3)) : ack_lat;
      end
      if (r_phase == 1) begin
        if (r_cnt == 0) begin
          bus.l15_transducer_ack = 1'b1;
          lr.dm = 1'b0; lr.rqtype = bus.transducer_l15_rqtype; lr.size = bus.transducer_l15_size;
          lr.addr = bus.transducer_l15_address; lr.data = bus.transducer_l15_data;
          seen_q.push_back(lr);
          r_phase = 2;
          r_cnt = rand_lat ? int'($urandom_range(0, 4)) : resp_lat;
        end else r_cnt--;
      end else if (r_phase == 2) begin
        if (r_cnt == 0) begin
          bus.l15_transducer_val = 1'b1;
          bus.l15_transducer_data_0 = salt ^ {32'h0, lr.addr};
          bus.l15_transducer_data_1 = {lr.data[31:0], lr.addr};
          bus.l15_transducer_returntype = {27'h0, lr.rqtype};
          r_phase = 0;
        end else r_cnt--;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  function automatic void plan(input int nif, input int ndm);
    logic last_dm, pick;
    last_dm = 1'b0;
    exp_own.delete();
    while (nif > 0 || ndm > 0) begin
      pick = (nif == 0) ? 1'b1 : (ndm == 0) ? 1'b0 : RR ? !last_dm : 1'b1;
      exp_own.push_back(pick);
      last_dm = pick;
      if (pick) ndm--; else nif--;
    end
  endfunction
  task automatic clear_obs();
    if_acks = 0; dm_acks = 0; if_resps = 0; dm_resps = 0; both = 0;
    ack_q.delete(); rown_q.delete(); rd0_q.delete(); rrt_q.delete(); seen_q.delete();
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; auto_l15 = 1'b0; r_phase = 0;
    if_q.delete(); dm_q.delete();
    bus.if_req_val = 1'b0; bus.dm_req_val = 1'b0;
    bus.l15_transducer_ack = 1'b0; bus.l15_transducer_val = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_obs();
  endtask
  task automatic push_req(input logic dm, input logic [31:0] addr, input logic [4:0] rqt, input logic [2:0] sz, input logic [63:0] d);
    req_t r;
    r.dm = dm; r.addr = addr; r.rqtype = rqt; r.size = sz; r.data = d;
    if (dm) dm_q.push_back(r); else if_q.push_back(r);
  endtask
  task automatic wait_resps(input int n, input int budget);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_resps + dm_resps >= n) begin timed_out = 1'b0; break; end
    end
  endtask
  task automatic wait_send(input int budget);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.transducer_l15_val === 1'b1) begin timed_out = 1'b0; break; end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.transducer_l15_val !== 1'b0) begin errors++; $display("FAIL reset_l15_val: got %b want 0", bus.transducer_l15_val); end
    checks++; if ({bus.if_req_ack, bus.dm_req_ack, bus.if_resp_val, bus.dm_resp_val} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {bus.if_req_ack, bus.dm_req_ack, bus.if_resp_val, bus.dm_resp_val}); end
    checks++; if ({bus.resp_data_0, bus.resp_data_1, bus.resp_returntype} !== 160'h0) begin errors++; $display("FAIL reset_resp: got %h want 0", {bus.resp_data_0, bus.resp_data_1, bus.resp_returntype}); end
    checks++; if (bus.transducer_l15_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.transducer_l15_address); end
    rst = 1'b0;
    clear_obs();
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask
  task automatic test_single_dm();
    reset_dut();
    auto_l15 = 1'b1; rand_lat = 1'b0; ack_lat = 2; resp_lat = 5;
    salt = 64'hDEADBEEF ^ 64'h80000040;
    push_req(1'b1, 32'h80000040, 5'd0, 3'd3, 64'h0);
    wait_resps(1, 60);
    repeat (5) @(negedge clk);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", timed_out); end
    checks++; if (dm_acks !== 1) begin errors++; $display("FAIL single_dm_ack: got %0d want 1", dm_acks); end
    checks++; if (dm_resps !== 1) begin errors++; $display("FAIL single_dm_resp: got %0d want 1", dm_resps); end
    checks++; if (bus.resp_data_0 !== 64'hDEADBEEF) begin errors++; $display("FAIL single_data0: got %h want deadbeef", bus.resp_data_0); end
    checks++; if (if_acks + if_resps !== 0) begin errors++; $display("FAIL single_if_silent: got %0d want 0", if_acks + if_resps); end
    checks++; if (seen_q.size() !== 1 || seen_q[0].addr !== 32'h80000040) begin errors++; $display("FAIL single_addr: got %0d reqs want 1 at 80000040", seen_q.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", bus.busy); end
  endtask
  task automatic test_arbitration();
    logic [2:0] exp3, got3;
    reset_dut();
    auto_l15 = 1'b1; rand_lat = 1'b0; ack_lat = 1; resp_lat = 1; salt = '0;
    for (int i = 0; i < 3; i++) begin
      push_req(1'b0, 32'h1000 + 32'(i * 8), 5'd0, 3'd3, 64'h0);
      push_req(1'b1, 32'h2000 + 32'(i * 8), 5'd1, 3'd3, 64'h0);
    end
    wait_resps(6, 200);
    exp3 = RR ? 3'b101 : 3'b111;
    got3 = 3'b000;
    for (int i = 0; i < 3 && i < ack_q.size(); i++) got3[i] = ack_q[i];
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL arb_timeout: got %b want 0", timed_out); end
    checks++; if (got3 !== exp3) begin errors++; $display("FAIL arb_first3: got %b want %b", got3, exp3); end
    plan(3, 3);
    checks++; if (ack_q !== exp_own) begin errors++; $display("FAIL arb_order: got %p want %p", ack_q, exp_own); end
    checks++; if (rown_q !== exp_own) begin errors++; $display("FAIL arb_resp_order: got %p want %p", rown_q, exp_own); end
    checks++; if (both !== 0) begin errors++; $display("FAIL arb_both: got %0d want 0", both); end
  endtask
  task automatic test_ack_stall();
    logic [4:0] t; logic [2:0] s; logic [31:0] a; logic [63:0] d;
    reset_dut();
    push_req(1'b1, 32'hCAFE0080, 5'd1, 3'd2, 64'h1122334455667788);
    wait_send(20);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_send_timeout: got %b want 0", timed_out); end
    t = bus.transducer_l15_rqtype; s = bus.transducer_l15_size; a = bus.transducer_l15_address; d = bus.transducer_l15_data;
    checks++; if ({t, s, a, d} !== {5'd1, 3'd2, 32'hCAFE0080, 64'h1122334455667788}) begin errors++; $display("FAIL stall_fields: got %h %h %h %h want 1 2 cafe0080 1122334455667788", t, s, a, d); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.transducer_l15_val !== 1'b1 || bus.dm_req_ack !== 1'b0 || bus.if_req_ack !== 1'b0 ||
          {bus.transducer_l15_rqtype, bus.transducer_l15_size, bus.transducer_l15_address, bus.transducer_l15_data} !== {t, s, a, d}) begin
        errors++; $display("FAIL stall_cycle%0d: got val=%b ack=%b addr=%h want val=1 ack=0 addr=%h", i, bus.transducer_l15_val, bus.dm_req_ack, bus.transducer_l15_address, a);
      end
      @(negedge clk);
    end
    bus.l15_transducer_ack = 1'b1;
    @(negedge clk);
    bus.l15_transducer_ack = 1'b0;
    checks++; if ({bus.dm_req_ack, bus.transducer_l15_val} !== 2'b10) begin errors++; $display("FAIL stall_ack: got ack=%b val=%b want ack=1 val=0", bus.dm_req_ack, bus.transducer_l15_val); end
    bus.l15_transducer_val = 1'b1; bus.l15_transducer_data_0 = 64'h0123; bus.l15_transducer_data_1 = 64'h4567; bus.l15_transducer_returntype = 32'h5;
    #1;
    checks++; if (bus.transducer_l15_req_ack !== 1'b1) begin errors++; $display("FAIL stall_req_ack: got %b want 1", bus.transducer_l15_req_ack); end
    @(negedge clk);
    bus.l15_transducer_val = 1'b0;
    checks++; if ({bus.dm_resp_val, bus.if_resp_val, bus.resp_data_0, bus.resp_data_1, bus.resp_returntype} !== {2'b10, 64'h0123, 64'h4567, 32'h5}) begin
      errors++; $display("FAIL stall_resp: got dm=%b if=%b d0=%h rt=%h want dm=1 if=0 d0=123 rt=5", bus.dm_resp_val, bus.if_resp_val, bus.resp_data_0, bus.resp_returntype); end
  endtask
  task automatic test_unsolicited();
    @(negedge clk);
    clear_obs();
    bus.l15_transducer_val = 1'b1; bus.l15_transducer_data_0 = 64'hBAD; bus.l15_transducer_returntype = 32'h9;
    #1;
    checks++; if (bus.transducer_l15_req_ack !== 1'b1) begin errors++; $display("FAIL unsol_req_ack: got %b want 1", bus.transducer_l15_req_ack); end
    @(negedge clk);
    bus.l15_transducer_val = 1'b0;
    #1 bus.if_req_val = 1'b1;
    #2 bus.if_req_val = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if_resps + dm_resps !== 0) begin errors++; $display("FAIL unsol_resp: got %0d want 0", if_resps + dm_resps); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL unsol_busy: got %b want 0", bus.busy); end
    checks++; if (bus.resp_data_0 !== 64'h0123) begin errors++; $display("FAIL unsol_hold: got %h want 123", bus.resp_data_0); end
    checks++; if (if_acks !== 0) begin errors++; $display("FAIL glitch_req: got %0d acks want 0", if_acks); end
  endtask
  task automatic test_reset_mid();
    reset_dut();
    push_req(1'b1, 32'h40, 5'd0, 3'd3, 64'h0);
    wait_send(20);
    bus.l15_transducer_ack = 1'b1;
    @(negedge clk);
    bus.l15_transducer_ack = 1'b0;
    checks++; if ({bus.busy, bus.transducer_l15_val} !== 2'b10) begin errors++; $display("FAIL mid_wait_state: got busy=%b val=%b want 1 0", bus.busy, bus.transducer_l15_val); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.busy, bus.transducer_l15_val, bus.dm_req_ack, bus.dm_resp_val, bus.transducer_l15_req_ack} !== 5'b0 || bus.transducer_l15_address !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got busy=%b val=%b addr=%h want all 0", bus.busy, bus.transducer_l15_val, bus.transducer_l15_address); end
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    repeat (2) @(negedge clk);
    bus.l15_transducer_val = 1'b1; bus.l15_transducer_data_0 = 64'h77;
    #1;
    checks++; if (bus.transducer_l15_req_ack !== 1'b1) begin errors++; $display("FAIL late_req_ack: got %b want 1", bus.transducer_l15_req_ack); end
    @(negedge clk);
    bus.l15_transducer_val = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if_resps + dm_resps !== 0 || bus.busy !== 1'b0) begin errors++; $display("FAIL late_dropped: got resps=%0d busy=%b want 0 0", if_resps + dm_resps, bus.busy); end
    checks++; if (bus.resp_data_0 !== 64'h0) begin errors++; $display("FAIL late_data: got %h want 0", bus.resp_data_0); end
    auto_l15 = 1'b1; rand_lat = 1'b0; ack_lat = 0; resp_lat = 0; salt = '0;
    push_req(1'b1, 32'h44, 5'd0, 3'd3, 64'h0);
    wait_resps(1, 50);
    checks++; if (timed_out !== 1'b0 || dm_resps !== 1 || dm_acks !== 1) begin errors++; $display("FAIL post_reset_txn: got resps=%0d acks=%0d want 1 1", dm_resps, dm_acks); end
    checks++; if (bus.resp_data_0 !== 64'h44) begin errors++; $display("FAIL post_reset_data: got %h want 44", bus.resp_data_0); end
  endtask
  task automatic test_random();
    int nif, ndm, n;
    req_t r;
    req_t ifx[$], dmx[$];
    logic own;
    reset_dut();
    auto_l15 = 1'b1; rand_lat = 1'b1; salt = {$urandom, $urandom};
    nif = int'($urandom_range(2, 6)); ndm = int'($urandom_range(2, 6)); n = nif + ndm;
    for (int i = 0; i < nif + ndm; i++) begin
      r.dm = i >= nif; r.rqtype = 5'($urandom); r.size = 3'($urandom); r.addr = $urandom; r.data = {$urandom, $urandom};
      if (r.dm) dmx.push_back(r); else ifx.push_back(r);
      push_req(r.dm, r.addr, r.rqtype, r.size, r.data);
    end
    plan(nif, ndm);
    wait_resps(n, 60 * n);
    repeat (3) @(negedge clk);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rand_timeout: got %b want 0", timed_out); end
    checks++; if (ack_q.size() !== n || seen_q.size() !== n || rd0_q.size() !== n) begin errors++; $display("FAIL rand_counts: got acks=%0d reqs=%0d resps=%0d want %0d", ack_q.size(), seen_q.size(), rd0_q.size(), n); end
    checks++; if (both !== 0) begin errors++; $display("FAIL rand_both: got %0d want 0", both); end
    if (ack_q.size() == n && seen_q.size() == n && rd0_q.size() == n) begin
      for (int k = 0; k < n; k++) begin
        own = exp_own[k];
        r = own ? dmx.pop_front() : ifx.pop_front();
        checks++; if (ack_q[k] !== own || rown_q[k] !== own) begin errors++; $display("FAIL rand_owner%0d: got ack=%b resp=%b want %b", k, ack_q[k], rown_q[k], own); end
        checks++; if ({seen_q[k].rqtype, seen_q[k].size, seen_q[k].addr, seen_q[k].data} !== {r.rqtype, r.size, r.addr, r.data}) begin
          errors++; $display("FAIL rand_fields%0d: got addr=%h data=%h want addr=%h data=%h", k, seen_q[k].addr, seen_q[k].data, r.addr, r.data); end
        checks++; if (rd0_q[k] !== (salt ^ {32'h0, r.addr}) || rrt_q[k] !== {27'h0, r.rqtype}) begin
          errors++; $display("FAIL rand_resp%0d: got d0=%h rt=%h want d0=%h rt=%h", k, rd0_q[k], rrt_q[k], salt ^ {32'h0, r.addr}, {27'h0, r.rqtype}); end
      end
    end
  endtask
  initial begin
    bus.if_req_val = 1'b0; bus.dm_req_val = 1'b0;
    bus.if_req_rqtype = '0; bus.dm_req_rqtype = '0; bus.if_req_size = '0; bus.dm_req_size = '0;
    bus.if_req_addr = '0; bus.dm_req_addr = '0; bus.if_req_data = '0; bus.dm_req_data = '0;
    bus.l15_transducer_ack = 1'b0; bus.l15_transducer_val = 1'b0;
    bus.l15_transducer_data_0 = '0; bus.l15_transducer_data_1 = '0; bus.l15_transducer_returntype = '0;
    test_reset();
    test_single_dm();
    test_arbitration();
    test_ack_stall();
    test_unsolicited();
    test_reset_mid();
    repeat (3) test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
